// File: rtl/edge_kernel_pkg.sv
// Shared definitions for the parametrised 3x3 gradient edge detector:
// kernel mode encodings, per-mode coefficient weights and width helpers.
package edge_kernel_pkg;

  typedef enum logic [1:0] {
    MODE_SOBEL   = 2'b00,
    MODE_PREWITT = 2'b01,
    MODE_SCHARR  = 2'b10,
    MODE_RSVD    = 2'b11
  } kernel_mode_e;

  // Gx rows are [-side 0 side; -mid 0 mid; -side 0 side]; Gy is the transpose.
  typedef struct packed {
    logic [3:0] side;
    logic [3:0] mid;
  } coef_t;

  localparam coef_t COEF_SOBEL   = '{side: 4'd1, mid: 4'd2};
  localparam coef_t COEF_PREWITT = '{side: 4'd1, mid: 4'd1};
  localparam coef_t COEF_SCHARR  = '{side: 4'd3, mid: 4'd10};

  function automatic int grad_w(input int data_w);
    return data_w + 6;
  endfunction

  function automatic coef_t coef_for(input logic [1:0] mode);
    case (mode)
      MODE_PREWITT: return COEF_PREWITT;
      MODE_SCHARR:  return COEF_SCHARR;
      default:      return COEF_SOBEL;
    endcase
  endfunction

endpackage

// File: rtl/edge_window_3x3.sv
// Raster-order 3x3 window generator: two line buffers, col/row counters and
// nine tap registers; flags windows centred on interior pixels only.
module edge_window_3x3
  import edge_kernel_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int COLS     = 360,
  parameter int ROWS     = 480,
  parameter int LB_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic              win_valid,
  output logic              win_last,
  output logic              frame_start,
  output logic              mid_frame
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  generate
    if (LB_DEPTH < COLS) begin : g_depth_check
      $error("edge_window_3x3: LB_DEPTH must be at least COLS");
    end
  endgenerate

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [AW-1:0]     addr;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] lb1 [LB_DEPTH];
  logic [DATA_W-1:0] lb2 [LB_DEPTH];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  assign addr        = AW'(col);
  assign last_col    = (col == COL_LAST);
  assign last_row    = (row == ROW_LAST);
  assign lb1_rd      = lb1[addr];
  assign lb2_rd      = lb2[addr];
  assign frame_start = we_i && (col == '0) && (row == '0);
  assign mid_frame   = (col != '0) || (row != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (we_i) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // lb1 holds the previous row, lb2 the one before; both are read at the
  // current column before being overwritten, so the window never sees a row wrap.
  always_ff @(posedge clk) begin
    if (we_i) begin
      lb1[addr] <= data_i;
      lb2[addr] <= lb1_rd;
      w0 <= w1;  w1 <= w2;  w2 <= lb2_rd;
      w3 <= w4;  w4 <= w5;  w5 <= lb1_rd;
      w6 <= w7;  w7 <= w8;  w8 <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= we_i && (row >= ROW_TWO) && (col >= COL_TWO);
      win_last  <= we_i && last_row && last_col;
    end
  end

endmodule

// File: rtl/edge_kernel_param.sv
// Parametrised 3x3 gradient edge detector (Sobel/Prewitt/Scharr) with optional
// binary thresholding; per-frame mode capture and a 3-stage arithmetic pipeline.
module edge_kernel_param
  import edge_kernel_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 8,
  parameter int COLS     = 360,
  parameter int ROWS     = 480,
  parameter int LB_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              we_i,
  input  logic [1:0]        mode_i,
  input  logic              thresh_en_i,
  input  logic [OUT_W-1:0]  thresh_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              valid_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int GRAD_W = grad_w(DATA_W);
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  generate
    if (OUT_W > GRAD_W) begin : g_width_check
      $error("edge_kernel_param: OUT_W must not exceed DATA_W+6");
    end
  endgenerate

  function automatic logic signed [GRAD_W-1:0] px(input logic [DATA_W-1:0] p);
    return signed'({{(GRAD_W - DATA_W){1'b0}}, p});
  endfunction

  function automatic logic [GRAD_W:0] abs_ext(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] a;
    a = g[GRAD_W-1] ? unsigned'(-g) : unsigned'(g);
    return {1'b0, a};
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [GRAD_W:0] m);
    if (|m[GRAD_W:OUT_W]) return OUT_MAX;
    return m[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] apply_thresh(input logic [OUT_W-1:0] v,
                                                    input logic             en,
                                                    input logic [OUT_W-1:0] thr);
    if (!en) return v;
    return (v >= thr) ? OUT_MAX : '0;
  endfunction

  logic [DATA_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic              win_valid;
  logic              win_last;
  logic              frame_start;
  logic              mid_frame;

  edge_window_3x3 #(
    .DATA_W  (DATA_W),
    .COLS    (COLS),
    .ROWS    (ROWS),
    .LB_DEPTH(LB_DEPTH)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .we_i       (we_i),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .w5         (w5),
    .w6         (w6),
    .w7         (w7),
    .w8         (w8),
    .win_valid  (win_valid),
    .win_last   (win_last),
    .frame_start(frame_start),
    .mid_frame  (mid_frame)
  );

  // Frame settings are sampled only with pixel (0,0); the threshold travels
  // down the pipeline so a new frame cannot alter the previous frame's tail.
  coef_t             coef_q;
  logic              ten_q;
  logic [OUT_W-1:0]  thr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= COEF_SOBEL;
      ten_q  <= 1'b0;
      thr_q  <= '0;
    end else if (frame_start) begin
      coef_q <= coef_for(mode_i);
      ten_q  <= thresh_en_i;
      thr_q  <= thresh_i;
    end
  end

  logic signed [GRAD_W-1:0] k_side, k_mid;
  logic signed [GRAD_W-1:0] gx_c, gy_c;

  assign k_side = signed'(GRAD_W'(coef_q.side));
  assign k_mid  = signed'(GRAD_W'(coef_q.mid));
  assign gx_c   = k_side * ((px(w2) - px(w0)) + (px(w8) - px(w6))) + k_mid * (px(w5) - px(w3));
  assign gy_c   = k_side * ((px(w6) - px(w0)) + (px(w8) - px(w2))) + k_mid * (px(w7) - px(w1));

  // S1: signed gradients
  logic signed [GRAD_W-1:0] gx_p1, gy_p1;
  logic                     ten_p1;
  logic [OUT_W-1:0]         thr_p1;
  logic                     vld_p1, last_p1;

  always_ff @(posedge clk) begin
    gx_p1  <= gx_c;
    gy_p1  <= gy_c;
    ten_p1 <= ten_q;
    thr_p1 <= thr_q;
  end

  // S2: |Gx| + |Gy|
  logic [GRAD_W:0]  mag_p2;
  logic             ten_p2;
  logic [OUT_W-1:0] thr_p2;
  logic             vld_p2, last_p2;

  always_ff @(posedge clk) begin
    mag_p2 <= abs_ext(gx_p1) + abs_ext(gy_p1);
    ten_p2 <= ten_p1;
    thr_p2 <= thr_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= win_valid;
      last_p1 <= win_last;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  // S3: saturate, threshold, output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      if (vld_p2) begin
        data_o <= apply_thresh(saturate(mag_p2), ten_p2, thr_p2);
      end
      valid_o <= vld_p2;
      done_o  <= vld_p2 && last_p2;
    end
  end

  // A next-frame pixel (0,0) accepted before done keeps the block busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_o <= 1'b0;
    end else if (frame_start) begin
      busy_o <= 1'b1;
    end else if (done_o && !mid_frame) begin
      busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_kernel_param.sv
// Bench for edge_kernel_param: table-driven frames plus reset and back-to-back
// sequences, checked against a frame-level convolution model.
module tb_edge_kernel_param;

  localparam int DATA_W   = 8;
  localparam int OUT_W    = 8;
  localparam int COLS     = 8;
  localparam int ROWS     = 6;
  localparam int LB_DEPTH = 512;
  localparam int NPIX     = ROWS * COLS;
  localparam int NOUT     = (ROWS - 2) * (COLS - 2);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_i;
  logic              we_i;
  logic [1:0]        mode_i;
  logic              thresh_en_i;
  logic [OUT_W-1:0]  thresh_i;
  logic [OUT_W-1:0]  data_o;
  logic              valid_o;
  logic              done_o;
  logic              busy_o;

  always #5 clk = ~clk;

  edge_kernel_param #(
    .DATA_W  (DATA_W),
    .OUT_W   (OUT_W),
    .COLS    (COLS),
    .ROWS    (ROWS),
    .LB_DEPTH(LB_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .we_i       (we_i),
    .mode_i     (mode_i),
    .thresh_en_i(thresh_en_i),
    .thresh_i   (thresh_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    int val;
    int cyc;
    int last;
  } exp_t;

  // kind: 0 flat, 1 vertical step (cols 0-3 = 0, cols 4-7 = hi), 2 random
  typedef struct {
    int kind;
    int hi;
    int mode;
    int te;
    int thr;
    int gap;
    int tab;
    int exp_edge;
    int exp_other;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   img[ROWS][COLS];
  int   got[2*NOUT];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   out_idx = 0;
  int   done_cnt = 0;
  int   pix = 0;
  int   tail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: direct 3x3 correlation with the kernel matrices of the chosen mode.
  function automatic int model(input int r, input int c, input int m, input int te, input int thr);
    int w[3];
    int gx, gy, mag, p;
    case (m)
      1:       w = '{1, 1, 1};
      2:       w = '{3, 10, 3};
      default: w = '{1, 2, 1};
    endcase
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p  = img[r-1+i][c-1+j];
        gx += (j - 1) * w[i] * p;
        gy += (i - 1) * w[j] * p;
      end
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (te != 0) mag = (mag >= thr) ? 255 : 0;
    return mag;
  endfunction

  task automatic monitor();
    exp_t e;
    if (valid_o) begin
      chk(exp_q.size() != 0, "unexpected_valid", 1, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(int'(data_o) == e.val, "data_o", int'(data_o), e.val);
        chk(cyc == e.cyc, "latency", cyc, e.cyc);
        chk(int'(done_o) == e.last, "done_pos", int'(done_o), e.last);
        if (out_idx < 2*NOUT) got[out_idx] = int'(data_o);
        out_idx++;
      end
    end else begin
      chk(!done_o, "done_without_valid", int'(done_o), 0);
    end
    if (done_o) done_cnt++;
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      chk(0, "missing_output", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    chk(int'(busy_o) == int'(pix != 0 || tail != 0), "busy", int'(busy_o), int'(pix != 0 || tail != 0));
    if (done_o) tail = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    if (!rst && we_i) begin
      if (pix == NPIX - 1) begin
        pix  = 0;
        tail = 1;
      end else begin
        pix++;
      end
    end
    #1;
  endtask

  task automatic build_image(input int kind, input int hi);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0:       img[r][c] = hi;
          1:       img[r][c] = (c <= 3) ? 0 : hi;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic run_frame(input int m, input int te, input int thr, input int gap,
                           input int scramble, input int nbeats);
    int p, r, c;
    p = 0;
    while (p < nbeats) begin
      if (gap > 0 && int'($urandom_range(99)) < gap) begin
        we_i   = 1'b0;
        data_i = 8'($urandom_range(255));
        if (scramble != 0) mode_i = 2'($urandom_range(3));
        tick();
      end else begin
        r = p / COLS;
        c = p % COLS;
        we_i   = 1'b1;
        data_i = 8'(img[r][c]);
        if (p == 0) begin
          mode_i      = 2'(m);
          thresh_en_i = 1'(te);
          thresh_i    = 8'(thr);
        end else if (scramble != 0) begin
          mode_i      = 2'($urandom_range(3));
          thresh_en_i = 1'($urandom_range(1));
          thresh_i    = 8'($urandom_range(255));
        end
        if (r >= 2 && c >= 2)
          exp_q.push_back('{model(r - 1, c - 1, m, te, thr), cyc + 4,
                            int'(r == ROWS - 1 && c == COLS - 1)});
        tick();
        p++;
      end
    end
  endtask

  task automatic wait_drain();
    we_i = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_table(input int n, input int e_edge, input int e_other);
    int cc, ev;
    for (int k = 0; k < n; k++) begin
      cc = (k % NOUT) % (COLS - 2) + 1;
      ev = (cc == 3 || cc == 4) ? e_edge : e_other;
      chk(got[k] == ev, "table_value", got[k], ev);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 100, 0, 0, 0,   0,  1, 0,   0};
    vecs[1]  = '{1, 10,  0, 0, 0,   0,  1, 40,  0};
    vecs[2]  = '{1, 10,  1, 0, 0,   0,  1, 30,  0};
    vecs[3]  = '{1, 10,  2, 0, 0,   0,  1, 160, 0};
    vecs[4]  = '{1, 100, 0, 0, 0,   0,  1, 255, 0};
    vecs[5]  = '{1, 10,  0, 1, 35,  0,  1, 255, 0};
    vecs[6]  = '{1, 10,  1, 1, 35,  0,  1, 0,   0};
    vecs[7]  = '{1, 10,  0, 0, 0,   40, 1, 40,  0};
    vecs[8]  = '{1, 10,  3, 0, 0,   0,  1, 40,  0};
    vecs[9]  = '{2, 0,   0, 0, 0,   20, 0, 0,   0};
    vecs[10] = '{2, 0,   2, 1, 128, 10, 0, 0,   0};
    vecs[11] = '{2, 0,   1, 0, 0,   0,  0, 0,   0};

    we_i = 1'b0;
    data_i = '0;
    mode_i = '0;
    thresh_en_i = 1'b0;
    thresh_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(data_o == '0, "reset_data_o", int'(data_o), 0);
    chk(!valid_o, "reset_valid_o", int'(valid_o), 0);
    chk(!done_o, "reset_done_o", int'(done_o), 0);
    chk(!busy_o, "reset_busy_o", int'(busy_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      build_image(vecs[v].kind, vecs[v].hi);
      out_idx  = 0;
      done_cnt = 0;
      run_frame(vecs[v].mode, vecs[v].te, vecs[v].thr, vecs[v].gap, 0, NPIX);
      wait_drain();
      chk(out_idx == NOUT, "frame_outputs", out_idx, NOUT);
      chk(done_cnt == 1, "frame_done", done_cnt, 1);
      if (vecs[v].tab != 0) check_table(NOUT, vecs[v].exp_edge, vecs[v].exp_other);
    end

    // Reset after 20 beats: in-flight windows must never reach the output.
    build_image(1, 10);
    run_frame(0, 0, 0, 0, 0, 20);
    we_i = 1'b0;
    rst  = 1'b1;
    exp_q.delete();
    pix  = 0;
    tail = 0;
    #1;
    chk(!valid_o, "midreset_valid_o", int'(valid_o), 0);
    chk(!busy_o, "midreset_busy_o", int'(busy_o), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    out_idx  = 0;
    done_cnt = 0;
    run_frame(1, 0, 0, 20, 1, NPIX);
    wait_drain();
    chk(out_idx == NOUT, "post_reset_outputs", out_idx, NOUT);
    chk(done_cnt == 1, "post_reset_done", done_cnt, 1);
    check_table(NOUT, 30, 0);

    // Back-to-back frames; busy continuity is checked every cycle by the monitor.
    out_idx  = 0;
    done_cnt = 0;
    run_frame(0, 0, 0, 0, 0, NPIX);
    run_frame(0, 0, 0, 0, 0, NPIX);
    wait_drain();
    chk(out_idx == 2*NOUT, "b2b_outputs", out_idx, 2*NOUT);
    chk(done_cnt == 2, "b2b_done", done_cnt, 2);
    check_table(2*NOUT, 40, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
